mmc5_xram_arb: RTL and testbench

MMC5_XRAM_ARB -- requirements
Module: mmc5_xram_arb

---
 rtl/mmc5_xram_arb_if.sv | 58 +++++
 rtl/mmc5_xram_arb.sv | 170 +++++++++++++++++
 tb/tb_mmc5_xram_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmc5_xram_arb_if.sv
// Bundle of the ExRAM arbiter's requester, RAM and read-return signals.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system's view: the requesters and the RAM macro.
interface mmc5_xram_arb_if #(
  parameter int AW = 10
);
  logic          ss_act;

  logic          ppu_req;
  logic          ppu_we;
  logic [AW-1:0] ppu_addr;
  logic [7:0]    ppu_wdat;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdat;

  logic          ss_req;
  logic          ss_we;
  logic [AW-1:0] ss_addr;
  logic [7:0]    ss_wdat;

  logic          ppu_ack;
  logic          cpu_ack;
  logic          ss_ack;

  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  logic [7:0]    rdat;
  logic          rd_vld;
  logic [1:0]    rd_id;

  modport slave (
    input  ss_act,
    input  ppu_req, ppu_we, ppu_addr, ppu_wdat,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdat,
    input  ss_req, ss_we, ss_addr, ss_wdat,
    input  ram_dout,
    output ppu_ack, cpu_ack, ss_ack,
    output ram_addr, ram_din, ram_we,
    output rdat, rd_vld, rd_id
  );

  modport master (
    output ss_act,
    output ppu_req, ppu_we, ppu_addr, ppu_wdat,
    output cpu_req, cpu_we, cpu_addr, cpu_wdat,
    output ss_req, ss_we, ss_addr, ss_wdat,
    output ram_dout,
    input  ppu_ack, cpu_ack, ss_ack,
    input  ram_addr, ram_din, ram_we,
    input  rdat, rd_vld, rd_id
  );
endinterface

// File: rtl/mmc5_xram_arb.sv
// MMC5 ExRAM arbiter. Three requesters (PPU, CPU and save-state) share one
// single-port RAM that has a one-cycle registered read. At most one access
// is granted per clock.
//
// Normal mode: the priority order is PPU > SS > CPU. A CPU that has lost
// CPU_MAX_WAIT arbitrations in a row is forced through ahead of the others.
// Save-state mode (ss_act=1): only the SS requester is served.
//
// Reads are fully pipelined. The grant edge registers the RAM address, the
// RAM returns its data one cycle later, and rdat captures that data at the
// edge after that. rd_vld and rd_id tell the owner that rdat is valid.
module mmc5_xram_arb #(
  parameter int CPU_MAX_WAIT = 3,
  parameter int AW           = 10
) (
  input logic              clk,
  input logic              map_rst,
  mmc5_xram_arb_if.slave   bus
);

  localparam logic [1:0] ID_PPU   = 2'd0;
  localparam logic [1:0] ID_CPU   = 2'd1;
  localparam logic [1:0] ID_SS    = 2'd2;
  localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);

  logic          ppu_ack_reg;
  logic          cpu_ack_reg;
  logic          ss_ack_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [7:0]    ram_din_reg;
  logic          ram_we_reg;
  logic          rd_p1_reg;
  logic          rd_p2_reg;
  logic [1:0]    id_p1_reg;
  logic [1:0]    id_p2_reg;
  logic          rd_vld_reg;
  logic [1:0]    rd_id_reg;
  logic [7:0]    rdat_reg;
  logic [3:0]    cpu_wait_reg;
  // Low for the first edge after reset release, so that no grant is made on it.
  logic          armed_reg;

  logic          elig_ppu;
  logic          elig_cpu;
  logic          elig_ss;
  logic          gnt_ppu;
  logic          gnt_cpu;
  logic          gnt_ss;
  logic          gnt_any;
  logic [1:0]    win_id;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [7:0]    win_wdat;

  // A requester whose ack is high this cycle is not eligible. This prevents
  // back-to-back grants to the same requester.
  always_comb begin
    elig_ppu = bus.ppu_req & ~ppu_ack_reg;
    elig_cpu = bus.cpu_req & ~cpu_ack_reg;
    elig_ss  = bus.ss_req  & ~ss_ack_reg;
  end

  // Choose at most one winner: save-state mode first, then forced CPU, then fixed priority.
  always_comb begin
    gnt_ppu = 1'b0;
    gnt_cpu = 1'b0;
    gnt_ss  = 1'b0;
    if (armed_reg) begin
      if (bus.ss_act) begin
        gnt_ss = elig_ss;
      end else if (elig_cpu && (cpu_wait_reg == WAIT_MAX)) begin
        gnt_cpu = 1'b1;
      end else if (elig_ppu) begin
        gnt_ppu = 1'b1;
      end else if (elig_ss) begin
        gnt_ss = 1'b1;
      end else begin
        gnt_cpu = elig_cpu;
      end
    end
    gnt_any = gnt_ppu | gnt_cpu | gnt_ss;
  end

  // Select the winner's command fields for the RAM port.
  always_comb begin
    win_id   = ID_PPU;
    win_we   = bus.ppu_we;
    win_addr = bus.ppu_addr;
    win_wdat = bus.ppu_wdat;
    if (gnt_cpu) begin
      win_id   = ID_CPU;
      win_we   = bus.cpu_we;
      win_addr = bus.cpu_addr;
      win_wdat = bus.cpu_wdat;
    end else if (gnt_ss) begin
      win_id   = ID_SS;
      win_we   = bus.ss_we;
      win_addr = bus.ss_addr;
      win_wdat = bus.ss_wdat;
    end
  end

  // Register the acks and the RAM command. Address and data hold when there is no grant.
  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      armed_reg    <= 1'b0;
      ppu_ack_reg  <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      ss_ack_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
    end else begin
      armed_reg   <= 1'b1;
      ppu_ack_reg <= gnt_ppu;
      cpu_ack_reg <= gnt_cpu;
      ss_ack_reg  <= gnt_ss;
      ram_we_reg  <= gnt_any & win_we;
      if (gnt_any) begin
        ram_addr_reg <= win_addr;
        ram_din_reg  <= win_wdat;
      end
    end
  end

  // Read return pipeline. It tracks ownership across the RAM latency and then captures ram_dout.
  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      rd_p1_reg  <= 1'b0;
      rd_p2_reg  <= 1'b0;
      id_p1_reg  <= '0;
      id_p2_reg  <= '0;
      rd_vld_reg <= 1'b0;
      rd_id_reg  <= '0;
      rdat_reg   <= '0;
    end else begin
      rd_p1_reg  <= gnt_any & ~win_we;
      id_p1_reg  <= win_id;
      rd_p2_reg  <= rd_p1_reg;
      id_p2_reg  <= id_p1_reg;
      rd_vld_reg <= rd_p2_reg;
      if (rd_p2_reg) begin
        rdat_reg  <= bus.ram_dout;
        rd_id_reg <= id_p2_reg;
      end
    end
  end

  // Count the arbitrations the CPU has lost in a row. Cleared on a CPU grant, on an idle CPU, or in save-state mode.
  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      cpu_wait_reg <= '0;
    end else if (bus.ss_act || !bus.cpu_req || gnt_cpu) begin
      cpu_wait_reg <= '0;
    end else if (armed_reg && elig_cpu && (cpu_wait_reg != WAIT_MAX)) begin
      cpu_wait_reg <= cpu_wait_reg + 4'd1;
    end
  end

  assign bus.ppu_ack  = ppu_ack_reg;
  assign bus.cpu_ack  = cpu_ack_reg;
  assign bus.ss_ack   = ss_ack_reg;
  assign bus.ram_addr = ram_addr_reg;
  assign bus.ram_din  = ram_din_reg;
  assign bus.ram_we   = ram_we_reg;
  assign bus.rdat     = rdat_reg;
  assign bus.rd_vld   = rd_vld_reg;
  assign bus.rd_id    = rd_id_reg;

endmodule

// File: tb/tb_mmc5_xram_arb.sv
// Self-checking bench for mmc5_xram_arb. Expected grants are queued in
// grant order when the stimulus is issued. A negedge monitor pops that queue
// on every ack, and on every read ack it schedules the expected read return.
module tb_mmc5_xram_arb;

  typedef struct {
    int         id;
    bit         we;
    logic [9:0] addr;
    logic [7:0] dat;
  } acc_t;

  typedef struct {
    int         id;
    logic [7:0] dat;
    int         cyc;
  } rd_t;

  logic clk = 1'b0;
  logic map_rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  acc_t ack_q[$];
  rd_t  rd_q[$];

  logic [7:0] ref_mem [1024];
  logic [7:0] mem [1024];
  bit         written [1024];

  mmc5_xram_arb_if #(.AW(10)) bus ();

  mmc5_xram_arb #(.CPU_MAX_WAIT(3), .AW(10)) dut (
    .clk     (clk),
    .map_rst (map_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input logic [9:0] a);
    if (a == 10'h155) return 8'hA7;
    return a[7:0] ^ 8'h5A;
  endfunction

  // RAM model: single port with a registered read that returns the old data on a same-edge write.
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr]     <= bus.ram_din;
      written[bus.ram_addr] <= 1'b1;
    end
    bus.ram_dout <= written[bus.ram_addr] ? mem[bus.ram_addr] : init_val(bus.ram_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue one expected grant, in grant order. A read expects whatever the reference memory holds at that point.
  task automatic push(input int id, input bit we, input logic [9:0] a, input logic [7:0] wd);
    acc_t e;
    e.id   = id;
    e.we   = we;
    e.addr = a;
    e.dat  = we ? wd : ref_mem[a];
    if (we) ref_mem[a] = wd;
    ack_q.push_back(e);
  endtask

  task automatic drive(input int id, input logic req, input logic we,
                       input logic [9:0] a, input logic [7:0] d);
    case (id)
      0: begin bus.ppu_req = req; bus.ppu_we = we; bus.ppu_addr = a; bus.ppu_wdat = d; end
      1: begin bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdat = d; end
      default: begin bus.ss_req = req; bus.ss_we = we; bus.ss_addr = a; bus.ss_wdat = d; end
    endcase
  endtask

  function automatic logic ack_of(input int id);
    case (id)
      0: return bus.ppu_ack;
      1: return bus.cpu_ack;
      default: return bus.ss_ack;
    endcase
  endfunction

  // Hold a request until it is acked, waiting at most 64 cycles. With keep=1 req stays high afterwards.
  task automatic access(input int id, input logic we, input logic [9:0] a,
                        input logic [7:0] d, input bit keep);
    bit got = 1'b0;
    drive(id, 1'b1, we, a, d);
    for (int n = 0; n < 64 && !got; n++) begin
      @(posedge clk);
      #1;
      got = ack_of(id);
    end
    chk("ack_seen", 64'(got), 64'd1);
    if (!keep) drive(id, 1'b0, we, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares acks, RAM commands and read returns against the scoreboard.
  always @(negedge clk) begin
    logic [2:0] acks;
    int         id;
    acc_t       e;
    rd_t        r;
    acks = {bus.ss_ack, bus.cpu_ack, bus.ppu_ack};
    if (map_rst) begin
      chk("rst_outs", 64'({acks, bus.ram_we, bus.rd_vld, bus.ram_addr, bus.ram_din,
                           bus.rdat, bus.rd_id}), 64'd0);
      rd_q.delete();
    end else begin
      chk("ack_onehot", 64'($countones(acks) <= 1), 64'd1);
      if (acks == 3'b000) begin
        chk("we_idle", 64'(bus.ram_we), 64'd0);
      end else if (ack_q.size() == 0) begin
        chk("ack_unexpected", 64'(acks), 64'd0);
      end else begin
        id = bus.ss_ack ? 2 : (bus.cpu_ack ? 1 : 0);
        e  = ack_q.pop_front();
        chk("ack_id", 64'(id), 64'(e.id));
        chk("ram_addr", 64'(bus.ram_addr), 64'(e.addr));
        chk("ram_we", 64'(bus.ram_we), 64'(e.we));
        if (e.we) begin
          chk("ram_din", 64'(bus.ram_din), 64'(e.dat));
        end else begin
          r.id  = e.id;
          r.dat = e.dat;
          r.cyc = cyc + 2;
          rd_q.push_back(r);
        end
      end
      if (bus.rd_vld) begin
        if (rd_q.size() == 0) begin
          chk("rd_spurious", 64'(bus.rd_vld), 64'd0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_id", 64'(bus.rd_id), 64'(r.id));
          chk("rdat", 64'(bus.rdat), 64'(r.dat));
          chk("rd_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(10'(i));
    map_rst    = 1'b1;
    bus.ss_act = 1'b0;
    drive(0, 1'b0, 1'b0, 10'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 10'h0, 8'h0);
    drive(2, 1'b0, 1'b0, 10'h0, 8'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 map_rst = 1'b0;
    idle(2);

    // A single CPU read of 0xA7 from address 0x155.
    push(1, 1'b0, 10'h155, 8'h00);
    access(1, 1'b0, 10'h155, 8'h00, 1'b0);
    idle(4);

    // Simultaneous one-shot reads are served in the order PPU, SS, CPU.
    push(0, 1'b0, 10'h001, 8'h00);
    push(2, 1'b0, 10'h002, 8'h00);
    push(1, 1'b0, 10'h003, 8'h00);
    fork
      access(0, 1'b0, 10'h001, 8'h00, 1'b0);
      access(2, 1'b0, 10'h002, 8'h00, 1'b0);
      access(1, 1'b0, 10'h003, 8'h00, 1'b0);
    join
    idle(5);

    // PPU and SS keep re-requesting; the CPU is forced through on its 4th eligible edge.
    push(0, 1'b0, 10'h100, 8'h00);
    push(2, 1'b0, 10'h200, 8'h00);
    push(0, 1'b0, 10'h101, 8'h00);
    push(1, 1'b0, 10'h300, 8'h00);
    push(2, 1'b0, 10'h201, 8'h00);
    fork
      begin
        access(0, 1'b0, 10'h100, 8'h00, 1'b1);
        access(0, 1'b0, 10'h101, 8'h00, 1'b0);
      end
      begin
        access(2, 1'b0, 10'h200, 8'h00, 1'b1);
        access(2, 1'b0, 10'h201, 8'h00, 1'b0);
      end
      access(1, 1'b0, 10'h300, 8'h00, 1'b0);
    join
    idle(5);

    // A PPU write followed back-to-back by an SS read of the same address returns the new data.
    push(0, 1'b1, 10'h020, 8'h99);
    push(2, 1'b0, 10'h020, 8'h00);
    fork
      access(0, 1'b1, 10'h020, 8'h99, 1'b0);
      access(2, 1'b0, 10'h020, 8'h00, 1'b0);
    join
    idle(5);

    // Save-state mode: only SS is served, and a CPU request cancelled during it never lands.
    bus.ss_act = 1'b1;
    push(2, 1'b0, 10'h3FF, 8'h00);
    push(0, 1'b1, 10'h3FF, 8'h55);
    fork
      access(0, 1'b1, 10'h3FF, 8'h55, 1'b0);
      access(2, 1'b0, 10'h3FF, 8'h00, 1'b0);
      begin
        drive(1, 1'b1, 1'b1, 10'h010, 8'hEE);
        idle(3);
        drive(1, 1'b0, 1'b1, 10'h010, 8'hEE);
        idle(3);
        bus.ss_act = 1'b0;
      end
    join
    push(2, 1'b0, 10'h3FF, 8'h00);
    access(2, 1'b0, 10'h3FF, 8'h00, 1'b0);
    idle(5);

    // Reset during the ack cycle of a CPU read: the read is dropped, and the first edge after release grants nothing.
    push(1, 1'b0, 10'h155, 8'h00);
    access(1, 1'b0, 10'h155, 8'h00, 1'b0);
    @(negedge clk);
    #1 map_rst = 1'b1;
    push(0, 1'b0, 10'h0AA, 8'h00);
    drive(0, 1'b1, 1'b0, 10'h0AA, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 map_rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_gap", 64'(bus.ppu_ack), 64'd0);
    @(posedge clk);
    #1 chk("rst_grant", 64'(bus.ppu_ack), 64'd1);
    drive(0, 1'b0, 1'b0, 10'h0AA, 8'h00);
    idle(6);

    chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
